// File: rtl/acc_stage_ctrl_pkg.sv
// Shared definitions for the accumulator stage controller.
package acc_stage_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Per-block result select codes, two bits per block in output_sel.
  localparam logic [1:0] OUT_SEL_WEST  = 2'b01;
  localparam logic [1:0] OUT_SEL_SOUTH = 2'b10;

  // Beats per accumulation group; each group yields one result per block.
  localparam int DATA_NUM_DEFAULT = 192;

endpackage

// File: rtl/acc_result_tracker.sv
// Per-block saturating result counters and the all-blocks-done reduction.
module acc_result_tracker #(
  parameter int NUM_BLOCKS = 4,
  parameter int BEAT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  count_en,
  input  logic [NUM_BLOCKS-1:0] mask,
  input  logic [NUM_BLOCKS-1:0] res_valid,
  input  logic [BEAT_W-1:0]     groups,
  output logic                  all_done
);

  logic [NUM_BLOCKS-1:0] lane_done;

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_lane
    logic [BEAT_W-1:0] cnt_q;
    logic [BEAT_W-1:0] cnt_nxt;

    // Count strobes from enabled blocks only, saturating at the group count.
    always_comb begin
      cnt_nxt = cnt_q;
      if (count_en && mask[i] && res_valid[i] && (cnt_q < groups))
        cnt_nxt = cnt_q + 1'b1;
    end

    // Counter register, cleared at the start of every stage.
    always_ff @(posedge clk) begin
      if (rst || clear) cnt_q <= '0;
      else              cnt_q <= cnt_nxt;
    end

    // Look at the post-update count so a strobe ends the stage on the same edge.
    assign lane_done[i] = !mask[i] || (cnt_nxt == groups);
  end

  assign all_done = &lane_done;

endmodule

// File: rtl/acc_stage_ctrl.sv
// Sequences one stage of a row of accumulator blocks: config, operand
// streaming for cfg_beats beats, result drain, then a done pulse.
module acc_stage_ctrl
  import acc_stage_ctrl_pkg::*;
#(
  parameter int NUM_BLOCKS    = 4,
  parameter int DATA_NUM      = DATA_NUM_DEFAULT,
  parameter int BEAT_W        = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [NUM_BLOCKS-1:0]   cfg_block_mask,
  input  logic [2*NUM_BLOCKS-1:0] cfg_output_sel,
  input  logic [BEAT_W-1:0]       cfg_beats,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    feed_valid,
  output logic                    stage_start,
  output logic [NUM_BLOCKS-1:0]   block_en,
  output logic [2*NUM_BLOCKS-1:0] output_sel,
  input  logic [NUM_BLOCKS-1:0]   res_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] DN = BEAT_W'(DATA_NUM);

  state_t                state;
  logic [NUM_BLOCKS-1:0] mask_q;
  logic [BEAT_W-1:0]     groups_q;
  logic [BEAT_W-1:0]     beats_q;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [DW-1:0]         drain_cnt;
  logic                  cfg_fire;
  logic                  cfg_bad;
  logic                  cfg_ok;
  logic                  last_beat;
  logic                  all_done;
  logic                  count_en;

  assign cfg_fire   = cfg_valid && cfg_ready;
  assign cfg_bad    = (cfg_beats == '0) || ((cfg_beats % DN) != '0);
  assign cfg_ok     = cfg_fire && !cfg_bad && (state == ST_IDLE);
  assign feed_valid = in_valid && in_ready;
  assign last_beat  = feed_valid && (beat_cnt == beats_q - 1'b1);
  // Results arriving while operands still stream are counted too.
  assign count_en   = (state == ST_STREAM) || (state == ST_DRAIN);

  acc_result_tracker #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .BEAT_W     (BEAT_W)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear     (cfg_ok),
    .count_en  (count_en),
    .mask      (mask_q),
    .res_valid (res_valid),
    .groups    (groups_q),
    .all_done  (all_done)
  );

  // Stage FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cfg_ready   <= 1'b1;
      in_ready    <= 1'b0;
      stage_start <= 1'b0;
      block_en    <= '0;
      output_sel  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      mask_q      <= '0;
      groups_q    <= '0;
      beats_q     <= '0;
      beat_cnt    <= '0;
      drain_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_fire) begin
            if (cfg_bad) begin
              // Rejected config: flag it and pulse done without starting.
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              mask_q      <= cfg_block_mask;
              groups_q    <= cfg_beats / DN;
              beats_q     <= cfg_beats;
              err         <= 1'b0;
              cfg_ready   <= 1'b0;
              busy        <= 1'b1;
              stage_start <= 1'b1;
              block_en    <= cfg_block_mask;
              output_sel  <= cfg_output_sel;
              state       <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          beat_cnt <= '0;
          in_ready <= 1'b1;
          state    <= ST_STREAM;
        end
        ST_STREAM: begin
          if (feed_valid) beat_cnt <= beat_cnt + 1'b1;
          if (last_beat) begin
            in_ready  <= 1'b0;
            drain_cnt <= '0;
            // Nothing left to wait for (e.g. empty mask): finish right away.
            if (all_done) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (all_done) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (drain_cnt == DW'(DRAIN_TIMEOUT - 1)) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          stage_start <= 1'b0;
          block_en    <= '0;
          output_sel  <= '0;
          busy        <= 1'b0;
          cfg_ready   <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_stage_ctrl.sv
// Directed bench for acc_stage_ctrl with hand-computed expectations.
module tb_acc_stage_ctrl;
  import acc_stage_ctrl_pkg::*;

  localparam int NB = 4;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [NB-1:0] cfg_block_mask;
  logic [2*NB-1:0] cfg_output_sel;
  logic [15:0]   cfg_beats;
  logic          in_valid;
  logic          in_ready;
  logic          feed_valid;
  logic          stage_start;
  logic [NB-1:0] block_en;
  logic [2*NB-1:0] output_sel;
  logic [NB-1:0] res_valid;
  logic          busy;
  logic          done;
  logic          err;

  int n_chk = 0;
  int n_err = 0;

  acc_stage_ctrl #(
    .NUM_BLOCKS    (NB),
    .DATA_NUM      (192),
    .BEAT_W        (16),
    .DRAIN_TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_block_mask (cfg_block_mask),
    .cfg_output_sel (cfg_output_sel),
    .cfg_beats      (cfg_beats),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .feed_valid     (feed_valid),
    .stage_start    (stage_start),
    .block_en       (block_en),
    .output_sel     (output_sel),
    .res_valid      (res_valid),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [NB-1:0] m, input logic [2*NB-1:0] sel, input logic [15:0] b);
    cfg_valid      = 1'b1;
    cfg_block_mask = m;
    cfg_output_sel = sel;
    cfg_beats      = b;
    tick();
    cfg_valid      = 1'b0;
  endtask

  // Drive operands while in_ready is high; counts forwarded beats and ready cycles.
  task automatic stream(input bit toggle, output int nfeed, output int ncyc);
    bit v;
    v = 1'b1;
    nfeed = 0;
    ncyc = 0;
    while (in_ready && ncyc < 5000) begin
      in_valid = v;
      #1;
      if (feed_valid) nfeed++;
      ncyc++;
      tick();
      if (toggle) v = !v;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_res(input logic [NB-1:0] v);
    res_valid = v;
    tick();
    res_valid = '0;
  endtask

  // Full-mask 192-beat stage, all blocks respond 20 cycles after the last beat.
  task automatic basic_stage(input string tag);
    int nf, nc;
    offer(4'b1111, {OUT_SEL_SOUTH, OUT_SEL_WEST, OUT_SEL_SOUTH, OUT_SEL_WEST}, 16'd192);
    chk({tag, "_load_start"}, stage_start, 1);
    chk({tag, "_load_en"}, block_en, 4'hF);
    chk({tag, "_load_sel"}, output_sel, 8'h99);
    chk({tag, "_load_rdy"}, {cfg_ready, in_ready, busy}, 3'b001);
    tick();
    chk({tag, "_stream_rdy"}, in_ready, 1);
    stream(1'b0, nf, nc);
    chk({tag, "_ready_cycles"}, nc, 192);
    chk({tag, "_feeds"}, nf, 192);
    for (int i = 0; i < 19; i++) tick();
    chk({tag, "_no_early_done"}, done, 0);
    pulse_res(4'hF);
    chk({tag, "_done"}, {done, err, stage_start}, 3'b101);
    tick();
    chk({tag, "_idle"}, {done, cfg_ready, busy, stage_start, block_en}, {4'b0100, 4'h0});
  endtask

  initial begin
    int nf, nc, c;
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_block_mask = '0;
    cfg_output_sel = '0;
    cfg_beats = '0;
    in_valid = 1'b0;
    res_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outs", {cfg_ready, in_ready, stage_start, busy, done, err}, 6'b100000);
    chk("reset_vec", {block_en, output_sel}, 12'h000);

    // Basic legal stage.
    basic_stage("basic");

    // Two groups, half the blocks, stalled input, stray strobes from disabled blocks.
    offer(4'b0101, 8'h00, 16'd384);
    tick();
    stream(1'b1, nf, nc);
    chk("multi_feeds", nf, 384);
    chk("multi_ready_cycles", nc, 767);
    pulse_res(4'b1111);
    chk("multi_d1", done, 0);
    pulse_res(4'b1010);
    pulse_res(4'b1010);
    chk("multi_ign", done, 0);
    pulse_res(4'b0001);
    chk("multi_d2", done, 0);
    pulse_res(4'b0001);
    chk("multi_sat", done, 0);
    pulse_res(4'b0100);
    chk("multi_done", {done, err}, 2'b10);
    tick();

    // Config errors.
    offer(4'b1111, 8'h00, 16'd0);
    chk("cfg0_err", {done, err, stage_start, cfg_ready, busy}, 5'b11010);
    tick();
    chk("cfg0_after", {done, err, stage_start}, 3'b010);
    offer(4'b1111, 8'h00, 16'd100);
    chk("cfg100_err", {done, err, stage_start, busy}, 4'b1100);
    tick();
    chk("cfg100_after", {done, err, stage_start}, 3'b010);

    // Legal config clears err; then drain timeout with only block 0 responding.
    offer(4'b0011, 8'h00, 16'd192);
    chk("clr_err", {err, stage_start}, 2'b01);
    tick();
    stream(1'b0, nf, nc);
    chk("to_feeds", nf, 192);
    res_valid = 4'b0001;
    c = 0;
    while (!done && c < 2000) begin
      tick();
      res_valid = '0;
      c++;
    end
    chk("to_cycles", c, TO);
    chk("to_err", err, 1);
    tick();
    chk("to_sticky", {done, err, busy}, 3'b010);

    // Reset in the middle of streaming.
    offer(4'b1111, 8'h00, 16'd192);
    chk("rst_cfg_clr", err, 0);
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_idle", {cfg_ready, stage_start, busy, done, in_ready}, 5'b10000);
    c = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) c++;
    end
    chk("midrst_nodone", c, 0);
    basic_stage("after_rst");

    // Empty mask: done straight after the last beat.
    offer(4'b0000, 8'h00, 16'd192);
    tick();
    stream(1'b0, nf, nc);
    chk("mask0_feeds", nf, 192);
    chk("mask0_done", {done, err, in_ready}, 3'b100);
    tick();
    chk("mask0_idle", {done, cfg_ready, busy}, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
